// File: rtl/mc_buffer_arbiter_if.sv
// mc_buffer_arbiter_if: requester and data-buffer signals shared by the arbiter and its environment
interface mc_buffer_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          buf_full;
  logic                          buf_write_request;
  logic [DATA_WIDTH-1:0]         buf_data_in;
  logic                          grant_valid;
  logic [IDW-1:0]                grant_id;
  modport master (
    output req_valid, req_data, buf_full,
    input  req_ready, buf_write_request, buf_data_in, grant_valid, grant_id
  );
  modport slave (
    input  req_valid, req_data, buf_full,
    output req_ready, buf_write_request, buf_data_in, grant_valid, grant_id
  );
endinterface

// File: rtl/mc_buffer_arbiter.sv
// mc_buffer_arbiter: round-robin burst arbiter sharing one data-buffer write port among NUM_REQ requesters
module mc_buffer_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 4,
  parameter int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int BW         = $clog2(BURST_LEN + 1)
) (
  input logic clk,
  input logic reset,
  mc_buffer_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, rr_nxt, grant_id, gid_nxt, pick;
  logic [BW-1:0]  beat_cnt, cnt_nxt;
  logic           found, burst, xfer;
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        pick  = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end
  // outputs are masked during reset so an aborted burst never writes in the reset cycle
  assign burst                 = (state == BURST) && !reset;
  assign xfer                  = burst && bus.req_valid[grant_id] && !bus.buf_full;
  assign bus.grant_valid       = burst;
  assign bus.grant_id          = reset ? '0 : grant_id;
  assign bus.req_ready         = (burst && !bus.buf_full) ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.buf_write_request = xfer;
  assign bus.buf_data_in       = burst ? bus.req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  always_comb begin
    state_nxt = state;
    gid_nxt   = grant_id;
    cnt_nxt   = beat_cnt;
    rr_nxt    = rr_ptr;
    if (state == IDLE) begin
      if (found) begin
        state_nxt = BURST;
        gid_nxt   = pick;
        cnt_nxt   = '0;
      end
    end else if (!bus.req_valid[grant_id] || (xfer && beat_cnt == BW'(BURST_LEN - 1))) begin
      state_nxt = IDLE;
      rr_nxt    = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end else if (xfer) begin
      cnt_nxt = beat_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      grant_id <= gid_nxt;
      beat_cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_mc_buffer_arbiter.sv
// tb_mc_buffer_arbiter: table-driven cycle vectors plus a grant-order sequence for mc_buffer_arbiter
module tb_mc_buffer_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mc_buffer_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(64)) bus();
  mc_buffer_arbiter #(.NUM_REQ(4), .DATA_WIDTH(64), .BURST_LEN(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       full;
    logic       gv;
    logic [1:0] gid;
    logic [3:0] rdy;
    logic       wr;
  } vec_t;
  vec_t        tbl[30];
  logic [63:0] pat[4];
  int          order[5] = '{0, 1, 2, 3, 0};
  int          checks = 0;
  int          failures = 0;
  function automatic vec_t mk(input int rst, v, full, gv, gid, rdy, wr);
    vec_t r;
    r.rst = 1'(rst); r.v = 4'(v); r.full = 1'(full);
    r.gv = 1'(gv); r.gid = 2'(gid); r.rdy = 4'(rdy); r.wr = 1'(wr);
    return r;
  endfunction
  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask
  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      pat[i] = 64'h0123_4567_89AB_CDE0 ^ {16'(i + 1), 48'h0} ^ 64'(i);
      bus.req_data[i*64 +: 64] = pat[i];
    end
    bus.req_valid = '0;
    bus.buf_full  = 1'b0;
    // rst, req_valid, buf_full -> grant_valid, grant_id, req_ready, buf_write_request
    tbl[0]  = mk(1, 'h0, 0, 0, 0, 'h0, 0);
    tbl[1]  = mk(1, 'hF, 0, 0, 0, 'h0, 0);
    tbl[2]  = mk(0, 'h4, 0, 0, 0, 'h0, 0);
    tbl[3]  = mk(0, 'h4, 0, 1, 2, 'h4, 1);
    tbl[4]  = mk(0, 'h4, 0, 1, 2, 'h4, 1);
    tbl[5]  = mk(0, 'h4, 0, 1, 2, 'h4, 1);
    tbl[6]  = mk(0, 'h4, 0, 1, 2, 'h4, 1);
    tbl[7]  = mk(0, 'h4, 0, 0, 0, 'h0, 0);
    tbl[8]  = mk(0, 'h4, 0, 1, 2, 'h4, 1);
    tbl[9]  = mk(0, 'h4, 0, 1, 2, 'h4, 1);
    tbl[10] = mk(0, 'h4, 1, 1, 2, 'h0, 0);
    tbl[11] = mk(0, 'h4, 1, 1, 2, 'h0, 0);
    tbl[12] = mk(0, 'h4, 1, 1, 2, 'h0, 0);
    tbl[13] = mk(0, 'h4, 0, 1, 2, 'h4, 1);
    tbl[14] = mk(0, 'h4, 0, 1, 2, 'h4, 1);
    tbl[15] = mk(0, 'h0, 0, 0, 0, 'h0, 0);
    tbl[16] = mk(0, 'h4, 0, 0, 0, 'h0, 0);
    tbl[17] = mk(0, 'h4, 0, 1, 2, 'h4, 1);
    tbl[18] = mk(1, 'h4, 0, 0, 0, 'h0, 0);
    tbl[19] = mk(0, 'hF, 0, 0, 0, 'h0, 0);
    tbl[20] = mk(0, 'hF, 0, 1, 0, 'h1, 1);
    tbl[21] = mk(0, 'h0, 0, 1, 0, 'h1, 0);
    tbl[22] = mk(0, 'hA, 0, 0, 0, 'h0, 0);
    tbl[23] = mk(0, 'hA, 0, 1, 1, 'h2, 1);
    tbl[24] = mk(0, 'hA, 0, 1, 1, 'h2, 1);
    tbl[25] = mk(0, 'h8, 0, 1, 1, 'h2, 0);
    tbl[26] = mk(0, 'h8, 0, 0, 0, 'h0, 0);
    tbl[27] = mk(0, 'h8, 0, 1, 3, 'h8, 1);
    tbl[28] = mk(0, 'h0, 0, 1, 3, 'h8, 0);
    tbl[29] = mk(0, 'h0, 0, 0, 0, 'h0, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 30; i++) begin
      reset         = tbl[i].rst;
      bus.req_valid = tbl[i].v;
      bus.buf_full  = tbl[i].full;
      @(negedge clk);
      chk("grant_valid", i, 64'(bus.grant_valid), 64'(tbl[i].gv));
      chk("req_ready", i, 64'(bus.req_ready), 64'(tbl[i].rdy));
      chk("buf_write_request", i, 64'(bus.buf_write_request), 64'(tbl[i].wr));
      chk("buf_data_in", i, bus.buf_data_in, tbl[i].gv ? pat[tbl[i].gid] : 64'h0);
      if (tbl[i].gv || tbl[i].rst) chk("grant_id", i, 64'(bus.grant_id), 64'(tbl[i].gid));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.req_valid = 4'hF;
    n = 0;
    for (int c = 0; c < 60 && n < 20; c++) begin
      @(negedge clk);
      if (bus.buf_write_request) begin
        chk("order_id", n, 64'(bus.grant_id), 64'(order[n/4]));
        chk("order_data", n, bus.buf_data_in, pat[order[n/4]]);
        n++;
      end
      @(posedge clk);
      #1;
    end
    chk("order_count", n, 64'(n), 64'd20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
